// File: rtl/insmem_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory loader.
package insmem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int MAX_WORDS = 256;
  localparam int CNT_W     = 18;

endpackage

// File: rtl/xor_checksum.sv
// 8-bit XOR accumulator with synchronous clear/enable and an equality flag.
module xor_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] cmp,
  output logic [7:0] acc,
  output logic       match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (clr) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

  assign match = (acc == cmp);

endmodule

// File: rtl/insmem_loader.sv
// Loads a framed byte stream (word count, payload, XOR checksum) into instruction
// memory and holds the CPU until a frame completes with a good checksum.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | taking word-count high byte
// LEN_LO | taking word-count low byte, length check
// DATA   | taking 4*len payload bytes, one write each
// CSUM   | taking checksum byte
// DONE   | image good, CPU released
// ERR    | frame rejected, CPU held
module insmem_loader
  import insmem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 4 * MAX_WORDS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int                max_words = MEM_BYTES / 4;
  localparam logic [CNT_W-1:0]  cnt_one   = 1;
  localparam logic [ADDR_W-1:0] addr_one  = 1;

  state_t            state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_rx;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              take;
  logic              clr;
  logic              take_data;
  logic              last_byte;
  logic              len_bad;
  logic              csum_ok;
  logic [7:0]        csum_acc;

  assign len_rx    = {len_hi, in_data};
  assign in_ready  = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign take      = in_valid && in_ready;
  assign take_data = take && (state == DATA);
  assign clr       = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign last_byte = ((byte_cnt + cnt_one) == {len, 2'b00});
  assign len_bad   = (len_rx == 16'd0) || (int'(len_rx) > max_words);

  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (clr) state_nxt = LEN_HI;
      LEN_HI: if (take) state_nxt = LEN_LO;
      LEN_LO: if (take) state_nxt = len_bad ? ERR : DATA;
      DATA:   if (take && last_byte) state_nxt = CSUM;
      CSUM:   if (take) state_nxt = csum_ok ? DONE : ERR;
      DONE:   if (clr) state_nxt = LEN_HI;
      ERR:    if (clr) state_nxt = LEN_HI;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_hi   <= 8'h00;
      len      <= 16'h0000;
      byte_cnt <= '0;
      addr_cnt <= '0;
    end else begin
      if (take && (state == LEN_HI)) len_hi <= in_data;
      if (take && (state == LEN_LO)) len <= len_rx;
      if (clr) begin
        byte_cnt <= '0;
        addr_cnt <= '0;
      end else if (take_data) begin
        byte_cnt <= byte_cnt + cnt_one;
        addr_cnt <= addr_cnt + addr_one;
      end
    end
  end

  // Write port is registered so each accepted byte is written the following cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
    end else begin
      mem_we <= take_data;
      if (take_data) begin
        mem_addr  <= addr_cnt;
        mem_wdata <= in_data;
      end
    end
  end

  xor_checksum u_csum (
    .clk   (CLK),
    .rst   (RST),
    .clr   (clr),
    .en    (take_data),
    .din   (in_data),
    .cmp   (in_data),
    .acc   (csum_acc),
    .match (csum_ok)
  );

endmodule

// File: tb/tb_insmem_loader.sv
// Randomized frame bench for insmem_loader with a frame-level reference model.
module tb_insmem_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  insmem_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   gap_pct = 0;
  wr_t  q[$];
  byte unsigned frame[$];
  logic [7:0] wmem [0:1023];
  logic exp_valid = 1'b0;
  logic exp_done  = 1'b0;
  logic exp_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Every cycle: writes must match the expected queue in order and cycle; status when settled.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check("write_missing", 32'(q[0].addr), 32'hFFFF);
      void'(q.pop_front());
    end
    if (mem_we) begin
      we_count++;
      wmem[mem_addr] = mem_wdata;
      if (q.size() == 0) begin
        check("unexpected_write", {22'd0, mem_addr}, 32'hFFFF);
      end else begin
        check("write_addr", {22'd0, mem_addr}, 32'(q[0].addr));
        check("write_data", {24'd0, mem_wdata}, 32'(q[0].data));
        check("write_cycle", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
    end
    if (exp_valid) begin
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("err", {31'd0, err}, {31'd0, exp_err});
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
      check("in_ready_idle", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic mk_frame(input int len, input bit good);
    byte unsigned x;
    byte unsigned b;
    frame.delete();
    x = 8'h00;
    frame.push_back(8'(len >> 8));
    frame.push_back(8'(len));
    for (int k = 0; k < 4 * len; k++) begin
      b = 8'($urandom_range(255));
      frame.push_back(b);
      x = x ^ b;
    end
    if (!good) x = x ^ 8'(1 << $urandom_range(7));
    frame.push_back(x);
  endtask

  task automatic do_start();
    exp_valid = 1'b0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // Model: frame layout decides which bytes are payload, their addresses, and the outcome.
  task automatic send(input int gap_at);
    int i = 0;
    int tries = 0;
    int len;
    int needed;
    bit legal;
    bit acc;
    byte unsigned x;
    len = (int'(frame[0]) << 8) | int'(frame[1]);
    legal = (len >= 1) && (len <= 256);
    needed = legal ? (2 + 4 * len + 1) : 2;
    while (i < frame.size() && i < needed) begin
      in_data  = frame[i];
      in_valid = ($urandom_range(99) >= gap_pct);
      @(negedge CLK);
      acc = in_valid && in_ready;
      if (acc && i >= 2 && i < 2 + 4 * len)
        q.push_back('{i - 2, int'(frame[i]), cyc + 1});
      @(posedge CLK);
      #1;
      if (acc) begin
        if (i == gap_at) begin
          in_valid = 1'b0;
          repeat (3) @(posedge CLK);
          #1;
        end
        i++;
      end
      tries++;
      if (tries > 5000) begin
        check("byte_accept_timeout", 32'(i), 32'(needed));
        break;
      end
    end
    in_valid = 1'b0;
    if (i == needed) begin
      x = 8'h00;
      if (legal) for (int k = 0; k < 4 * len; k++) x = x ^ frame[2 + k];
      exp_done  = legal && (frame[needed - 1] == x);
      exp_err   = !exp_done;
      exp_valid = 1'b1;
    end
  endtask

  int we0;

  initial begin
    RST = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_addr_wdata", {14'd0, mem_addr, mem_wdata}, 32'd0);
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;

    // One-word load with known literal contents.
    gap_pct = 0;
    frame = '{8'h00, 8'h01, 8'h20, 8'h11, 8'h80, 8'h20, 8'h91};
    we0 = we_count;
    do_start();
    send(-1);
    check("one_word_done", {29'd0, done, err, cpu_hold}, 32'b100);
    @(posedge CLK);
    #1;
    check("one_word_writes", 32'(we_count - we0), 32'd4);
    check("one_word_mem", {wmem[0], wmem[1], wmem[2], wmem[3]}, 32'h20118020);

    // Same frame, bad checksum.
    frame = '{8'h00, 8'h01, 8'h20, 8'h11, 8'h80, 8'h20, 8'h00};
    we0 = we_count;
    do_start();
    send(-1);
    check("bad_csum_status", {29'd0, done, err, cpu_hold}, 32'b011);
    @(posedge CLK);
    #1;
    check("bad_csum_writes", 32'(we_count - we0), 32'd4);

    // Illegal lengths: 0 and 257.
    frame = '{8'h00, 8'h00};
    we0 = we_count;
    do_start();
    send(-1);
    check("len0_status", {28'd0, done, err, cpu_hold, in_ready}, 32'b0110);
    frame = '{8'h01, 8'h01};
    do_start();
    send(-1);
    check("len257_status", {28'd0, done, err, cpu_hold, in_ready}, 32'b0110);
    repeat (2) @(posedge CLK);
    #1;
    check("bad_len_writes", 32'(we_count - we0), 32'd0);

    // Two-word frame with a 3-cycle valid gap mid-payload.
    mk_frame(2, 1'b1);
    we0 = we_count;
    do_start();
    send(4);
    check("gap_done", {31'd0, done}, 32'd1);
    @(posedge CLK);
    #1;
    check("gap_writes", 32'(we_count - we0), 32'd8);

    // Reset in the middle of DATA, then a good reload.
    mk_frame(1, 1'b1);
    do_start();
    begin
      byte unsigned full[$];
      full = frame;
      frame = full[0:3];
      send(-1);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      q.delete();
      check("midrst_outputs", {17'd0, cpu_hold, in_ready, mem_we, done, err, mem_addr},
            {17'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
      check("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
    end
    mk_frame(1, 1'b1);
    we0 = we_count;
    do_start();
    send(-1);
    check("reload_done", {31'd0, done}, 32'd1);
    @(posedge CLK);
    #1;
    check("reload_writes", 32'(we_count - we0), 32'd4);

    // Randomized frames, including the maximum legal length.
    for (int f = 0; f < 14; f++) begin
      mk_frame((f == 5) ? 256 : int'($urandom_range(1, 8)), $urandom_range(3) != 0);
      gap_pct = int'($urandom_range(0, 40));
      do_start();
      send(-1);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(255));
      repeat (2) @(posedge CLK);
      #1;
      in_valid = 1'b0;
      check("queue_drained", 32'(q.size()), 32'd0);
    end

    exp_valid = 1'b0;
    @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/insmem_loader.md
# insmem_loader

Program loader that writes the byte-addressed instruction memory read by the fetch stage. Accepts a framed byte stream on a valid/ready interface: 16-bit word count, payload bytes, then an XOR checksum. Writes each payload byte to consecutive memory addresses starting at 0. Holds the processor in reset-hold until a frame completes with a correct checksum.

## Interface
- `ADDR_W`, 10: instruction-memory byte-address width.
- `MEM_BYTES`, 1024: memory depth in bytes. The maximum frame length is MEM_BYTES/4 words.

- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `start`  in  1  pulse that opens a load session. Honoured only in IDLE, DONE or ERR; ignored in all other states.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory byte write enable.
- `mem_addr`  out  ADDR_W  write byte address.
- `mem_wdata`  out  8  write byte.
- `cpu_hold`  out  1  processor must not fetch while high.
- `done`  out  1  last frame loaded with a good checksum (level).
- `err`  out  1  last frame rejected (level).

## Operation
- The block uses one clock; reset is asynchronous and active-high.
- A byte is accepted when `in_valid && in_ready`.
- FSM states and transitions:
  - IDLE: wait for `start`, then go to LEN_HI.
  - LEN_HI: accept the high byte of the word count, then go to LEN_LO.
  - LEN_LO: accept the low byte, then check the count.
    - len==0 or len>MEM_BYTES/4: go to ERR.
    - Otherwise: go to DATA.
  - DATA: accept exactly 4·len bytes, then go to CSUM.
  - CSUM: accept one byte.
    - Byte equals the XOR of all payload bytes: go to DONE.
    - Otherwise: go to ERR.
  - DONE / ERR: on `start`, go to LEN_HI.
- `in_ready` is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in IDLE, DONE and ERR. Bytes presented while `in_ready` is 0 are not consumed.
- Payload byte order:
  - Payload byte k is written to address k.
  - The first byte of each word is its most-significant byte, at the lowest address. This matches the fetch stage's big-endian concatenation.
- The length bytes and the checksum byte are never written to memory and are excluded from the checksum.
- On each `start` taken:
  - The address counter, byte counter and checksum accumulator clear.
  - `done` and `err` clear.
- Address arithmetic:
  - The address counter is ADDR_W bits and increments by 1 per written byte.
  - The length check guarantees it never wraps within a frame.
  - The byte counter is 18 bits and compares against {len,2'b00}.
- `cpu_hold` is 0 only in DONE and 1 in every other state, including ERR.
- ERR does not undo bytes already written; memory content after ERR is unspecified.
- `RST` in any state forces IDLE and the output reset values on the spot. Any partially loaded image is unspecified.

## Timing
- Reset values:
  - `cpu_hold`=1.
  - `in_ready`=0, `mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0.
  - `done`=0, `err`=0.
- `in_ready` is decoded combinationally from the state register only. It never depends on `in_valid`.
- Write latency: a byte accepted at edge n appears on `mem_we`/`mem_addr`/`mem_wdata` for exactly the cycle following edge n. Writes are registered.
- Throughput is one byte per cycle with no bubbles. `in_valid` may drop at any cycle; no write is issued for a cycle with no acceptance.
- `done`/`err` rise in the cycle after the CSUM byte is accepted.
  - For ERR on length, they rise the cycle after the LEN_LO byte is accepted.
- `cpu_hold` falls together with `done` rising.
- The last payload write always completes no later than the cycle in which the CSUM byte is accepted, so memory is complete when `cpu_hold` falls.
- `start` in the same cycle as an acceptance in DONE/ERR is impossible, because `in_ready`=0 there.

## Structure
- Package `insmem_loader_pkg` holds:
  - the FSM state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - the `MAX_WORDS` constant, equal to MEM_BYTES/4;
  - the byte-counter width constant.
- One sub-module, `xor_checksum`: an 8-bit accumulator with synchronous clear and enable, and a `match` output comparing against an input byte.
- The FSM, counters and write-port registers live in `insmem_loader`.

## Test plan
- Reset check: assert `RST` with `in_valid`=1 → `cpu_hold`=1, `in_ready`=0, `mem_we`=0, `done`=`err`=0. No byte is consumed before `start`.
- One-word load: `start`, then bytes 00 01 20 11 80 20 91 → writes addr0..3 = 20,11,80,20 on four consecutive cycles; then `done`=1, `cpu_hold`=0, `err`=0.
- Bad checksum: the same frame with checksum 00 → all four writes still occur; then `err`=1, `cpu_hold`=1, `done`=0.
- Illegal length: frames 00 00 and 01 01 (257 > 256) → `err`=1 the cycle after the second byte, zero `mem_we` pulses, `in_ready`=0.
- Backpressure/gaps: a two-word frame with `in_valid` low for 3 cycles after payload byte 2 → no writes during the gap, addresses 0..7 contiguous, `done`=1.
- Reset mid-DATA: `RST` after 2 payload bytes → outputs return to reset values immediately. A following `start` plus a good one-word frame → writes begin again at addr 0 and `done`=1.
